// File: rtl/s_port_arb_pkg.sv
// Shared definitions for the per-slave request stage: command encoding,
// arbiter FSM states and default widths.
package s_port_arb_pkg;

  localparam logic CMD_READ  = 1'b0;
  localparam logic CMD_WRITE = 1'b1;

  localparam int DEF_N_M    = 2;
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_DEPTH  = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } arb_state_e;

endpackage

// File: rtl/s_port_arb_id_fifo.sv
// Master-ID FIFO for outstanding reads. Pointers carry an extra MSB so that
// full and empty are distinguishable; the caller guards push/pop.
module id_fifo
  import s_port_arb_pkg::*;
#(
  parameter int W     = 1,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           din,
  output logic [W-1:0]           dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count = wr_ptr - rd_ptr;
  assign dout  = mem[rd_ptr[AW-1:0]];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is not reset; the pointers alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/s_port_arb.sv
// Per-slave request stage: round-robin arbitration over masters, slave req/ack
// handshake, and in-order routing of read responses via a master-ID FIFO.
module s_port_arb
  import s_port_arb_pkg::*;
#(
  parameter int N_M    = DEF_N_M,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_M-1:0]        m_req,
  input  logic [N_M*ADDR_W-1:0] m_addr,
  input  logic [N_M-1:0]        m_cmd,
  input  logic [N_M*DATA_W-1:0] m_wdata,
  output logic [N_M-1:0]        m_req_sent,
  output logic [N_M-1:0]        m_ack,
  output logic [N_M-1:0]        m_resp,
  output logic [DATA_W-1:0]     m_rdata,
  output logic                  s_req,
  output logic [ADDR_W-1:0]     s_addr,
  output logic                  s_cmd,
  output logic [DATA_W-1:0]     s_wdata,
  input  logic                  s_ack,
  input  logic                  s_resp,
  input  logic [DATA_W-1:0]     s_rdata,
  output logic                  resp_err
);

  localparam int ID_W  = $clog2(N_M);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  arb_state_e        state;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   gnt_id;
  logic [ID_W-1:0]   cand_id;
  logic              cand_found;
  logic [ID_W:0]     scan_idx;
  logic              read_ok;

  logic [ADDR_W-1:0] addr_arr  [N_M];
  logic [DATA_W-1:0] wdata_arr [N_M];

  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [ID_W-1:0]   fifo_head;
  logic [CNT_W-1:0]  fifo_count;

  for (genvar i = 0; i < N_M; i++) begin : g_unpack
    assign addr_arr[i]  = m_addr[i*ADDR_W +: ADDR_W];
    assign wdata_arr[i] = m_wdata[i*DATA_W +: DATA_W];
  end

  assign read_ok = (fifo_count < CNT_W'(DEPTH));

  // First eligible master at or after rr_ptr, wrapping modulo N_M.
  // NOTE: every always_comb output gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    cand_found = 1'b0;
    cand_id    = '0;
    scan_idx   = '0;
    for (int k = 0; k < N_M; k++) begin
      scan_idx = {1'b0, rr_ptr} + (ID_W+1)'(k);
      if (scan_idx >= (ID_W+1)'(N_M)) scan_idx = scan_idx - (ID_W+1)'(N_M);
      if (!cand_found && m_req[scan_idx[ID_W-1:0]] &&
          (m_cmd[scan_idx[ID_W-1:0]] == CMD_WRITE || read_ok)) begin
        cand_found = 1'b1;
        cand_id    = scan_idx[ID_W-1:0];
      end
    end
  end

  assign fifo_pop  = s_resp && !fifo_empty;
  assign fifo_push = (state == ST_ISSUE) && s_ack && (s_cmd == CMD_READ) &&
                     (!fifo_full || fifo_pop);

  id_fifo #(
    .W     (ID_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (gnt_id),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      rr_ptr     <= '0;
      gnt_id     <= '0;
      s_req      <= 1'b0;
      s_addr     <= '0;
      s_cmd      <= CMD_READ;
      s_wdata    <= '0;
      m_req_sent <= '0;
      m_ack      <= '0;
    end else begin
      m_req_sent <= '0;
      m_ack      <= '0;
      case (state)
        ST_IDLE: begin
          // The acked master still shows m_req while its m_ack pulse is out;
          // sit that cycle out so a stale request is never re-granted.
          if (cand_found && (m_ack == '0)) begin
            gnt_id              <= cand_id;
            s_addr              <= addr_arr[cand_id];
            s_cmd               <= m_cmd[cand_id];
            s_wdata             <= wdata_arr[cand_id];
            s_req               <= 1'b1;
            m_req_sent[cand_id] <= 1'b1;
            state               <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (s_ack) begin
            s_req         <= 1'b0;
            m_ack[gnt_id] <= 1'b1;
            rr_ptr        <= (gnt_id == ID_W'(N_M - 1)) ? '0 : gnt_id + 1'b1;
            state         <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Response routing runs independently of the request FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_resp   <= '0;
      m_rdata  <= '0;
      resp_err <= 1'b0;
    end else begin
      m_resp   <= '0;
      resp_err <= 1'b0;
      if (s_resp) begin
        if (!fifo_empty) begin
          m_resp[fifo_head] <= 1'b1;
          m_rdata           <= s_rdata;
        end else begin
          resp_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_s_port_arb.sv
// Self-checking bench for s_port_arb: table of single transactions followed by
// hand-written response, FIFO-full, same-cycle push/pop and reset sequences.
module tb_s_port_arb;
  import s_port_arb_pkg::*;

  localparam int N_M    = 2;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;

  localparam logic [ADDR_W-1:0] ADDR0 = 32'h8000_0010;
  localparam logic [ADDR_W-1:0] ADDR1 = 32'h4000_0020;
  localparam logic [DATA_W-1:0] WD0   = 32'hDEAD_BEEF;
  localparam logic [DATA_W-1:0] WD1   = 32'h1234_5678;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [N_M-1:0]        m_req = '0;
  logic [N_M*ADDR_W-1:0] m_addr;
  logic [N_M-1:0]        m_cmd = '0;
  logic [N_M*DATA_W-1:0] m_wdata;
  logic [N_M-1:0]        m_req_sent;
  logic [N_M-1:0]        m_ack;
  logic [N_M-1:0]        m_resp;
  logic [DATA_W-1:0]     m_rdata;
  logic                  s_req;
  logic [ADDR_W-1:0]     s_addr;
  logic                  s_cmd;
  logic [DATA_W-1:0]     s_wdata;
  logic                  s_ack = 1'b0;
  logic                  s_resp = 1'b0;
  logic [DATA_W-1:0]     s_rdata = '0;
  logic                  resp_err;

  assign m_addr  = {ADDR1, ADDR0};
  assign m_wdata = {WD1, WD0};

  always #5 clk = ~clk;

  s_port_arb #(
    .N_M    (N_M),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .m_req      (m_req),
    .m_addr     (m_addr),
    .m_cmd      (m_cmd),
    .m_wdata    (m_wdata),
    .m_req_sent (m_req_sent),
    .m_ack      (m_ack),
    .m_resp     (m_resp),
    .m_rdata    (m_rdata),
    .s_req      (s_req),
    .s_addr     (s_addr),
    .s_cmd      (s_cmd),
    .s_wdata    (s_wdata),
    .s_ack      (s_ack),
    .s_resp     (s_resp),
    .s_rdata    (s_rdata),
    .resp_err   (resp_err)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One transaction: request fields, s_req cycles before s_ack, expected
  // one-hot grant and expected ticks from driving m_req to seeing s_req.
  typedef struct {
    logic [N_M-1:0] req;
    logic [N_M-1:0] cmd;
    int             ack_wait;
    logic [N_M-1:0] gnt;
    int             lat;
  } vec_t;

  vec_t vecs [8];

  task automatic run_txn(input vec_t v);
    int lat;
    lat   = 0;
    m_req = v.req;
    m_cmd = v.cmd;
    do begin
      tick();
      lat++;
    end while (!s_req && lat < 10);
    check("issue_latency", 64'(lat), 64'(v.lat));
    if (s_req) begin
      check("req_sent", 64'(m_req_sent), 64'(v.gnt));
      check("s_addr", 64'(s_addr), 64'(v.gnt[1] ? ADDR1 : ADDR0));
      check("s_wdata", 64'(s_wdata), 64'(v.gnt[1] ? WD1 : WD0));
      check("s_cmd", 64'(s_cmd), 64'(|(v.gnt & v.cmd)));
      for (int i = 1; i < v.ack_wait; i++) begin
        tick();
        check("req_sent_single", 64'(m_req_sent), 64'(0));
        check("s_req_hold", 64'(s_req), 64'(1));
      end
      s_ack = 1'b1;
      tick();
      s_ack = 1'b0;
      check("m_ack", 64'(m_ack), 64'(v.gnt));
      check("s_req_drop", 64'(s_req), 64'(0));
    end
    m_req = '0;
  endtask

  task automatic resp(input logic [DATA_W-1:0] data, input logic [N_M-1:0] exp_resp,
                      input logic [DATA_W-1:0] exp_data, input logic exp_err);
    s_resp  = 1'b1;
    s_rdata = data;
    tick();
    s_resp  = 1'b0;
    check("m_resp", 64'(m_resp), 64'(exp_resp));
    check("m_rdata", 64'(m_rdata), 64'(exp_data));
    check("resp_err", 64'(resp_err), 64'(exp_err));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1);
  end

  initial begin
    vecs[0] = '{2'b01, 2'b01, 2, 2'b01, 1};  // single write, ack on 2nd s_req cycle
    vecs[1] = '{2'b10, 2'b10, 1, 2'b10, 2};  // master 1 write, pointer wraps to 0
    vecs[2] = '{2'b11, 2'b11, 1, 2'b01, 2};  // both requesting: 0,1,0,1
    vecs[3] = '{2'b11, 2'b11, 1, 2'b10, 2};
    vecs[4] = '{2'b11, 2'b11, 3, 2'b01, 2};
    vecs[5] = '{2'b11, 2'b11, 1, 2'b10, 2};
    vecs[6] = '{2'b10, 2'b00, 1, 2'b10, 2};  // master 1 read
    vecs[7] = '{2'b01, 2'b00, 1, 2'b01, 2};  // master 0 read

    // Reset state
    tick();
    check("rst_s_req", 64'(s_req), 64'(0));
    check("rst_s_addr", 64'(s_addr), 64'(0));
    check("rst_m_outs", 64'({m_req_sent, m_ack, m_resp, resp_err}), 64'(0));
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) run_txn(vecs[i]);

    // Reads answered in ack order: master 1 first, then master 0
    resp(32'h11, 2'b10, 32'h11, 1'b0);
    resp(32'h22, 2'b01, 32'h22, 1'b0);
    tick();
    check("rdata_hold", 64'(m_rdata), 64'(32'h22));
    check("resp_idle", 64'(m_resp), 64'(0));

    // Response with nothing outstanding is dropped
    resp(32'h33, 2'b00, 32'h22, 1'b1);
    tick();
    check("resp_err_pulse", 64'(resp_err), 64'(0));

    // Fill the ID FIFO with four master-0 reads
    for (int i = 0; i < DEPTH; i++) run_txn('{2'b01, 2'b00, 1, 2'b01, (i == 0) ? 1 : 2});
    m_req = 2'b01;
    m_cmd = 2'b00;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("full_blocks_read", 64'(s_req), 64'(0));
    end
    m_req = 2'b11;
    m_cmd = 2'b10;
    tick();
    check("full_write_issue", 64'(s_req), 64'(1));
    check("full_write_sent", 64'(m_req_sent), 64'(2'b10));
    check("full_write_cmd", 64'(s_cmd), 64'(CMD_WRITE));
    s_ack = 1'b1;
    tick();
    s_ack = 1'b0;
    m_req = 2'b01;
    check("full_write_ack", 64'(m_ack), 64'(2'b10));
    for (int i = 0; i < 3; i++) begin
      tick();
      check("still_full", 64'(s_req), 64'(0));
    end
    resp(32'h44, 2'b01, 32'h44, 1'b0);
    tick();
    check("read_after_pop", 64'(s_req), 64'(1));
    check("read_after_pop_sent", 64'(m_req_sent), 64'(2'b01));

    // Ack (push) and response (pop) in the same cycle: count stays at 3
    s_ack   = 1'b1;
    s_resp  = 1'b1;
    s_rdata = 32'h55;
    tick();
    s_ack  = 1'b0;
    s_resp = 1'b0;
    m_req  = '0;
    check("pp_ack", 64'(m_ack), 64'(2'b01));
    check("pp_resp", 64'(m_resp), 64'(2'b01));
    check("pp_rdata", 64'(m_rdata), 64'(32'h55));
    for (int i = 0; i < 3; i++) resp(32'h60 + DATA_W'(i), 2'b01, 32'h60 + DATA_W'(i), 1'b0);
    resp(32'h70, 2'b00, 32'h62, 1'b1);

    // Reset in the middle of ISSUE with two reads outstanding
    run_txn('{2'b10, 2'b00, 1, 2'b10, 1});
    run_txn('{2'b01, 2'b00, 1, 2'b01, 2});
    m_req = 2'b10;
    m_cmd = 2'b00;
    tick();
    tick();
    check("pend_issue", 64'(s_req), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    check("arst_s_req", 64'(s_req), 64'(0));
    check("arst_s_fields", 64'({s_addr, s_cmd, s_wdata}), 64'(0));
    check("arst_m_outs", 64'({m_req_sent, m_ack, m_resp, resp_err}), 64'(0));
    check("arst_rdata", 64'(m_rdata), 64'(0));
    m_req = '0;
    tick();
    rst_n = 1'b1;
    resp(32'h80, 2'b00, 32'h0, 1'b1);
    m_req = 2'b11;
    m_cmd = 2'b11;
    tick();
    check("post_rst_issue", 64'(s_req), 64'(1));
    check("post_rst_gnt", 64'(m_req_sent), 64'(2'b01));
    m_req = '0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
